// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, runs a single-outstanding req/ready fetch to instruction memory,
// and presents {pc+4, instruction, valid} to decode. Decode can freeze the stage,
// and EXE can redirect it with a branch that flushes IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // Hazard stall from decode
  input  logic        i_freeze,
  // Redirect from EXE
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_addr,
  // Instruction memory port
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  // IF/ID register
  output logic [31:0] o_pc_out,
  output logic [31:0] o_instruction,
  output logic        o_valid
);

  // StFetch: request outstanding, result consumed when it arrives.
  // StHold:  result parked in r_buf because decode was frozen; no request.
  // StDrain: a branch arrived mid-fetch; wait out the old request, then redirect.
  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StHold  = 2'b01,
    StDrain = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;

  logic [31:0] r_buf;
  logic [31:0] w_buf_next;

  logic [31:0] r_redir;
  logic [31:0] w_redir_next;

  logic [31:0] r_pc_out;
  logic [31:0] w_pc_out_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;
  logic        r_valid;
  logic        w_valid_next;

  // PC increment wraps modulo 2^32
  assign w_pc_plus4 = r_pc + 32'd4;

  // Memory interface: address is the PC itself, so it stays stable until the PC moves,
  // which only happens on a completed request or from StHold (no request pending).
  assign o_imem_req  = ~i_rst & ((r_state == StFetch) | (r_state == StDrain));
  assign o_imem_addr = r_pc;

  assign o_pc_out      = r_pc_out;
  assign o_instruction = r_instr;
  assign o_valid       = r_valid;

  // Next-state, next-PC and next IF/ID contents
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_buf_next    = r_buf;
    w_redir_next  = r_redir;
    w_pc_out_next = r_pc_out;
    w_instr_next  = r_instr;
    w_valid_next  = r_valid;

    case (r_state)
      StFetch: begin
        if (i_branch_taken) begin
          // Flush overrides freeze; the in-flight fetch is on the wrong path
          w_pc_out_next = 32'h0;
          w_instr_next  = 32'h0;
          w_valid_next  = 1'b0;
          if (i_imem_ready) begin
            w_pc_next = i_branch_addr;
          end else begin
            w_redir_next = i_branch_addr;
            w_state_next = StDrain;
          end
        end else if (i_imem_ready) begin
          if (!i_freeze) begin
            w_pc_out_next = w_pc_plus4;
            w_instr_next  = i_imem_rdata;
            w_valid_next  = 1'b1;
            w_pc_next     = w_pc_plus4;
          end else begin
            // Decode can't take it yet; park the word so it is not re-fetched
            w_buf_next   = i_imem_rdata;
            w_state_next = StHold;
          end
        end else if (!i_freeze) begin
          // Waiting on memory: hand decode a bubble
          w_pc_out_next = 32'h0;
          w_instr_next  = 32'h0;
          w_valid_next  = 1'b0;
        end
      end

      StHold: begin
        if (i_branch_taken) begin
          w_buf_next    = 32'h0;
          w_pc_next     = i_branch_addr;
          w_pc_out_next = 32'h0;
          w_instr_next  = 32'h0;
          w_valid_next  = 1'b0;
          w_state_next  = StFetch;
        end else if (!i_freeze) begin
          w_pc_out_next = w_pc_plus4;
          w_instr_next  = r_buf;
          w_valid_next  = 1'b1;
          w_pc_next     = w_pc_plus4;
          w_state_next  = StFetch;
        end
      end

      StDrain: begin
        // IF/ID remains a bubble until the redirected fetch returns
        w_pc_out_next = 32'h0;
        w_instr_next  = 32'h0;
        w_valid_next  = 1'b0;
        if (i_imem_ready) begin
          // Response belongs to the abandoned path; newest redirect target wins
          w_pc_next    = i_branch_taken ? i_branch_addr : r_redir;
          w_state_next = StFetch;
        end else if (i_branch_taken) begin
          w_redir_next = i_branch_addr;
        end
      end

      default: begin
        w_state_next = StFetch;
      end
    endcase
  end

  // State, PC, buffer and IF/ID registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StFetch;
      r_pc     <= RESET_PC;
      r_buf    <= 32'h0;
      r_redir  <= 32'h0;
      r_pc_out <= 32'h0;
      r_instr  <= 32'h0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_buf    <= w_buf_next;
      r_redir  <= w_redir_next;
      r_pc_out <= w_pc_out_next;
      r_instr  <= w_instr_next;
      r_valid  <= w_valid_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small variable-latency instruction memory model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;

  int unsigned mem_wait;
  int unsigned mem_cnt;
  int unsigned n_checks;
  int unsigned n_errors;

  if_stage #(
    .RESET_PC(32'h0000_0000)
  ) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_freeze       (freeze),
    .i_branch_taken (branch_taken),
    .i_branch_addr  (branch_addr),
    .o_imem_req     (imem_req),
    .o_imem_addr    (imem_addr),
    .i_imem_rdata   (imem_rdata),
    .i_imem_ready   (imem_ready),
    .o_pc_out       (pc_out),
    .o_instruction  (instruction),
    .o_valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory completes a request after mem_wait extra cycles; data is a tagged address
  assign imem_ready = imem_req && (mem_cnt >= mem_wait);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk) begin
    if (rst || !imem_req || imem_ready) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned wait_states);
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    mem_wait     = wait_states;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_cnt  = 0;

    // Reset state and zero-wait streaming
    do_reset(0);
    rst = 1'b1;
    #1;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_instr", instruction, 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("req_after_rst", 32'(imem_req), 32'd1);
    tick();
    check_eq("zw_pc0", pc_out, 32'd4);
    check_eq("zw_ins0", instruction, 32'hA5A5_0000);
    check_eq("zw_val0", 32'(valid), 32'd1);
    tick();
    check_eq("zw_pc1", pc_out, 32'd8);
    check_eq("zw_ins1", instruction, 32'hA5A5_0004);
    tick();
    check_eq("zw_pc2", pc_out, 32'd12);
    check_eq("zw_ins2", instruction, 32'hA5A5_0008);
    check_eq("zw_addr", imem_addr, 32'd12);

    // Latency-3 memory
    do_reset(2);
    tick();
    check_eq("l3_addr_a", imem_addr, 32'h0);
    check_eq("l3_val_a", 32'(valid), 32'd0);
    tick();
    check_eq("l3_addr_b", imem_addr, 32'h0);
    check_eq("l3_val_b", 32'(valid), 32'd0);
    tick();
    check_eq("l3_pc", pc_out, 32'd4);
    check_eq("l3_val", 32'(valid), 32'd1);
    check_eq("l3_addr_next", imem_addr, 32'd4);
    tick();
    check_eq("l3_bubble", 32'(valid), 32'd0);

    // Freeze as the addr-8 word returns
    do_reset(0);
    tick();
    tick();
    check_eq("fz_pre_pc", pc_out, 32'd8);
    freeze = 1'b1;
    tick();
    check_eq("fz_pc_a", pc_out, 32'd8);
    check_eq("fz_ins_a", instruction, 32'hA5A5_0004);
    check_eq("fz_val_a", 32'(valid), 32'd1);
    check_eq("fz_req_a", 32'(imem_req), 32'd0);
    tick();
    check_eq("fz_pc_b", pc_out, 32'd8);
    check_eq("fz_req_b", 32'(imem_req), 32'd0);
    freeze = 1'b0;
    tick();
    check_eq("fz_rel_pc", pc_out, 32'd12);
    check_eq("fz_rel_ins", instruction, 32'hA5A5_0008);
    check_eq("fz_rel_addr", imem_addr, 32'd12);
    check_eq("fz_rel_req", 32'(imem_req), 32'd1);

    // Branch while a latency-3 fetch of 0x10 is outstanding
    do_reset(0);
    tick();
    tick();
    tick();
    tick();
    check_eq("br_pre_addr", imem_addr, 32'h10);
    mem_wait     = 2;
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    branch_taken = 1'b0;
    check_eq("br_val", 32'(valid), 32'd0);
    check_eq("br_ins", instruction, 32'h0);
    check_eq("br_addr_a", imem_addr, 32'h10);
    check_eq("br_req_a", 32'(imem_req), 32'd1);
    tick();
    check_eq("br_addr_b", imem_addr, 32'h10);
    check_eq("br_val_b", 32'(valid), 32'd0);
    tick();
    check_eq("br_redir", imem_addr, 32'h100);
    check_eq("br_drop", 32'(valid), 32'd0);
    mem_wait = 0;
    tick();
    check_eq("br_first_pc", pc_out, 32'h104);
    check_eq("br_first_ins", instruction, 32'hA5A5_0100);
    check_eq("br_first_val", 32'(valid), 32'd1);

    // Branch and freeze together while in HOLD
    freeze = 1'b1;
    tick();
    check_eq("hb_req", 32'(imem_req), 32'd0);
    check_eq("hb_hold_pc", pc_out, 32'h104);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    check_eq("hb_val", 32'(valid), 32'd0);
    check_eq("hb_ins", instruction, 32'h0);
    check_eq("hb_addr", imem_addr, 32'h200);
    tick();
    check_eq("hb_pc", pc_out, 32'h204);
    check_eq("hb_ins2", instruction, 32'hA5A5_0200);

    // Reset in the middle of a drain
    mem_wait     = 2;
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    tick();
    branch_taken = 1'b0;
    check_eq("dr_addr", imem_addr, 32'h204);
    check_eq("dr_val", 32'(valid), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("dr_rst_addr", imem_addr, 32'h0);
    check_eq("dr_rst_val", 32'(valid), 32'd0);
    check_eq("dr_rst_req", 32'(imem_req), 32'd0);
    rst      = 1'b0;
    mem_wait = 0;
    #1;
    check_eq("dr_req", 32'(imem_req), 32'd1);
    tick();
    check_eq("dr_fetch_pc", pc_out, 32'd4);
    check_eq("dr_fetch_val", 32'(valid), 32'd1);

    // PC wrap at the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check_eq("wr_val", 32'(valid), 32'd0);
    check_eq("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wr_pc", pc_out, 32'h0);
    check_eq("wr_ins", instruction, 32'h5A5A_FFFC);
    check_eq("wr_val2", 32'(valid), 32'd1);
    check_eq("wr_next", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and fetches from an instruction memory over a req/ready handshake with variable latency.
- Presents {pc+4, instruction, valid} to decode; honours the decode-stage hazard freeze and the EXE-stage branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- freeze  in  1  hazard stall from decode; IF/ID register and PC hold.
- branch_taken  in  1  redirect request from EXE; flushes IF/ID.
- branch_addr  in  32  redirect target (word-aligned).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address (= PC).
- imem_rdata  in  32  fetched instruction; valid in the cycle imem_ready=1.
- imem_ready  in  1  memory completes the current request this cycle.
- pc_out  out  32  IF/ID: fetch address + 4 of the held instruction.
- instruction  out  32  IF/ID: held instruction.
- valid  out  1  IF/ID: instruction is live (0 = bubble).

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, state<=FETCH, pc_out<=0, instruction<=0, valid<=0, hold buffer and redirect register cleared.
- imem_req is 0 in the reset cycle. The instruction memory shares rst, so no stale response can arrive after reset.
- Handshake: imem_addr=pc. While imem_req=1 and imem_ready=0, imem_addr is stable. Only one request is outstanding at a time.
- FETCH state (imem_req=1), priority from highest to lowest:
  - branch_taken & imem_ready: drop rdata; pc<=branch_addr; flush IF/ID; stay FETCH.
  - branch_taken & ~imem_ready: redir<=branch_addr; flush IF/ID; go DRAIN.
  - imem_ready & ~freeze: IF/ID<={pc+4, imem_rdata, 1}; pc<=pc+4; stay FETCH (back-to-back fetch).
  - imem_ready & freeze: buf<=imem_rdata; IF/ID holds; go HOLD.
  - otherwise: IF/ID holds if freeze=1, else IF/ID<={0,0,0} (bubble while waiting).
- HOLD state (imem_req=0):
  - branch_taken: drop buf; pc<=branch_addr; flush IF/ID; go FETCH.
  - ~freeze: IF/ID<={pc+4, buf, 1}; pc<=pc+4; go FETCH.
  - freeze: everything holds.
- DRAIN state (imem_req=1, address = old pc, held stable):
  - branch_taken: redir<=branch_addr (newest target wins); IF/ID stays flushed.
  - imem_ready: drop rdata; pc<=redir (or branch_addr if branch_taken this cycle); go FETCH.
- Flush means IF/ID<={0, 32'h0, 0}. Flush overrides freeze.
- The PC adder is 32-bit, wrapping mod 2^32: 32'hFFFF_FFFC + 4 = 0.
- State encoding is 2-bit (FETCH, HOLD, DRAIN); the unused code goes to FETCH.
- Latency: an instruction is visible on the IF/ID outputs the cycle after the edge where imem_ready=1 (0-wait-state memory yields 1 instruction per cycle).

Test Plan:
- Reset then zero-wait memory (imem_ready=1 always, rdata=addr^32'hA5A5_0000), RESET_PC=0: successive cycles show pc_out 4, 8, 12 with matching instructions, valid=1. Outputs are all 0 during reset.
- Latency-3 memory: imem_addr=0 is held 3 cycles; valid=0 meanwhile; then pc_out=4, valid=1 for one cycle; imem_addr becomes 4.
- freeze=1 asserted as imem_ready returns the instruction for addr 8: IF/ID keeps the addr-4 instruction; imem_req=0. After 2 cycles freeze=0: IF/ID shows pc_out=12 with the buffered instruction and no re-fetch; next imem_addr=12.
- branch_taken with branch_addr=0x100 while a latency-3 fetch of 0x10 is outstanding: valid=0 immediately; imem_addr stays 0x10 until ready; the response is discarded; next imem_addr=0x100; first valid output is pc_out=0x104.
- branch_taken and freeze both high during HOLD: flush wins (valid=0, instruction=0); buffer is dropped; imem_addr=branch_addr next cycle.
- Reset asserted mid-DRAIN: next cycle state=FETCH, imem_addr=RESET_PC, valid=0. PC wrap check: branch to 0xFFFF_FFFC then fetch gives pc_out=0, next imem_addr=0.
